// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a ripple chain,
// with the carry held in a register between digits and a start/done handshake.
module serial_addsub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nx_s;
    logic [CW-1:0]          cnt_r;
    logic [WIDTH-1:0]       op_a_r;
    logic [WIDTH-1:0]       op_b_r;
    logic [WIDTH-1:0]       acc_r;
    logic                   carry_r;
    logic [WIDTH-1:0]       sum_r;
    logic                   cout_r;
    logic                   overflow_r;
    logic                   zero_r;
    logic                   done_r;

    logic [DIGIT-1:0]       dsum_s;
    logic                   cy_s;
    logic                   msb_cin_s;
    logic                   last_s;
    logic [WIDTH+DIGIT-1:0] acc_ext_s;
    logic [WIDTH+DIGIT-1:0] a_ext_s;
    logic [WIDTH+DIGIT-1:0] b_ext_s;
    logic [WIDTH-1:0]       acc_nx_s;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode; the final digit is the cycle with cnt at N-1
    always_comb begin
        state_nx_s = state_r;
        last_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                last_s = (cnt_r == LAST);
                if (cnt_r == LAST) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Full-adder chain over the low digit; msb_cin_s ends as the carry into the top cell
    always_comb begin
        dsum_s    = '0;
        cy_s      = carry_r;
        msb_cin_s = carry_r;
        for (int i = 0; i < DIGIT; i++) begin
            msb_cin_s = cy_s;
            dsum_s[i] = op_a_r[i] ^ op_b_r[i] ^ cy_s;
            cy_s      = (op_a_r[i] & op_b_r[i]) | (cy_s & (op_a_r[i] ^ op_b_r[i]));
        end
    end

    // Widened vectors let the shifts work even when DIGIT == WIDTH
    assign acc_ext_s = {dsum_s, acc_r};
    assign acc_nx_s  = acc_ext_s[WIDTH+DIGIT-1:DIGIT];
    assign a_ext_s   = {{DIGIT{1'b0}}, op_a_r};
    assign b_ext_s   = {{DIGIT{1'b0}}, op_b_r};

    // Operand latch, digit datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r      <= '0;
            op_a_r     <= '0;
            op_b_r     <= '0;
            acc_r      <= '0;
            carry_r    <= 1'b0;
            sum_r      <= '0;
            cout_r     <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_a_r  <= a;
                        op_b_r  <= sub ? ~b : b;
                        carry_r <= sub;
                        acc_r   <= '0;
                        cnt_r   <= '0;
                    end
                end
                RUN: begin
                    op_a_r  <= a_ext_s[WIDTH+DIGIT-1:DIGIT];
                    op_b_r  <= b_ext_s[WIDTH+DIGIT-1:DIGIT];
                    carry_r <= cy_s;
                    acc_r   <= acc_nx_s;
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_s) begin
                        sum_r      <= acc_nx_s;
                        cout_r     <= cy_s;
                        overflow_r <= msb_cin_s ^ cy_s;
                        zero_r     <= (acc_nx_s == '0);
                        done_r     <= 1'b1;
                    end
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign ready    = (state_r == IDLE);
    assign busy     = (state_r != IDLE);
    assign done     = done_r;
    assign sum      = sum_r;
    assign cout     = cout_r;
    assign overflow = overflow_r;
    assign zero     = zero_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: 32/4 main instance plus 8/1 and 8/8 corner instances.
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        ready, busy, done, cout, overflow, zero;
    logic [31:0] sum;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = 8'h0;
    logic [7:0]  b8 = 8'h0;
    logic        ready_1, busy_1, done_1, cout_1, ovf_1, zero_1;
    logic [7:0]  sum_1;
    logic        ready_8, busy_8, done_8, cout_8, ovf_8, zero_8;
    logic [7:0]  sum_8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(32), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout),
        .overflow(overflow), .zero(zero)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(1)) dut_d1 (
        .clk(clk), .rst(rst), .start(start8), .sub(1'b0), .a(a8), .b(b8),
        .ready(ready_1), .busy(busy_1), .done(done_1), .sum(sum_1), .cout(cout_1),
        .overflow(ovf_1), .zero(zero_1)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(8)) dut_d8 (
        .clk(clk), .rst(rst), .start(start8), .sub(1'b0), .a(a8), .b(b8),
        .ready(ready_8), .busy(busy_8), .done(done_8), .sum(sum_8), .cout(cout_8),
        .overflow(ovf_8), .zero(zero_8)
    );

    // Launch one 32-bit operation and return the cycles from start edge to done (-1 on timeout)
    task automatic run32(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                         output int lat);
        @(negedge clk);
        a = av; b = bv; sub = sv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({sum, cout, overflow, zero, done, ready, busy} !== {32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got sum=%h c=%b v=%b z=%b d=%b r=%b b=%b, expected zeros with ready=1",
                     sum, cout, overflow, zero, done, ready, busy);
        end
        n_checks++;
        if ({ready_1, ready_8, done_1, done_8} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_state8: got %b expected 1100", {ready_1, ready_8, done_1, done_8});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        int lat;
        run32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL add_wrap_latency: got %0d expected 8", lat);
        end
        n_checks++;
        if ({sum, cout, overflow, zero} !== {32'h0000_0000, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_wrap_result: got %h c=%b v=%b z=%b expected 00000000 c=1 v=0 z=1",
                     sum, cout, overflow, zero);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({done, ready, sum} !== {1'b0, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL done_one_cycle: got done=%b ready=%b sum=%h expected 0 1 00000000", done, ready, sum);
        end
        run32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
        n_checks++;
        if ({sum, cout, overflow, zero} !== {32'h8000_0000, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_ovf: got %h c=%b v=%b z=%b expected 80000000 c=0 v=1 z=0",
                     sum, cout, overflow, zero);
        end
    endtask

    task automatic test_sub();
        int lat;
        run32(32'd5, 32'd7, 1'b1, lat);
        n_checks++;
        if ({sum, cout, overflow, zero} !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_5_7: got %h c=%b v=%b z=%b expected fffffffe c=0 v=0 z=0",
                     sum, cout, overflow, zero);
        end
        run32(32'd7, 32'd5, 1'b1, lat);
        n_checks++;
        if ({sum, cout, overflow} !== {32'h0000_0002, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_7_5: got %h c=%b v=%b expected 00000002 c=1 v=0", sum, cout, overflow);
        end
        run32(32'h8000_0000, 32'd1, 1'b1, lat);
        n_checks++;
        if ({sum, cout, overflow, zero} !== {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_min_1: got %h c=%b v=%b z=%b expected 7fffffff c=1 v=1 z=0",
                     sum, cout, overflow, zero);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        a = 32'h10; b = 32'h20; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                break;
            end
            if (c == 3) begin
                start = 1'b1; a = 32'h1; b = 32'h1;
            end else begin
                start = 1'b0;
            end
        end
        n_checks++;
        if (lat !== 8 || sum !== 32'h30) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got lat=%0d sum=%h expected lat=8 sum=00000030", lat, sum);
        end
        start = 1'b1; a = 32'd3; b = 32'd4; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if ({done, busy, sum} !== {1'b0, 1'b1, 32'h30}) begin
            n_fail++;
            $display("FAIL b2b_accept: got done=%b busy=%b sum=%h expected 0 1 00000030", done, busy, sum);
        end
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        n_checks++;
        if (lat !== 8 || sum !== 32'h7) begin
            n_fail++;
            $display("FAIL b2b_result: got lat=%0d sum=%h expected lat=8 sum=00000007", lat, sum);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({sum, cout, overflow, zero, done, ready, busy} !== {32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got sum=%h c=%b v=%b z=%b d=%b r=%b b=%b expected zeros with ready=1",
                     sum, cout, overflow, zero, done, ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        n_checks++;
        if (seen !== 0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL no_done_after_reset: got %0d pulses ready=%b expected 0 pulses ready=1", seen, ready);
        end
    endtask

    task automatic test_width8();
        int lat1, lat8;
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat1 = -1; lat8 = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done_1 && lat1 < 0) lat1 = c;
            if (done_8 && lat8 < 0) lat8 = c;
        end
        n_checks++;
        if (lat1 !== 8 || lat8 !== 1) begin
            n_fail++;
            $display("FAIL w8_latency: got d1=%0d d8=%0d expected 8 and 1", lat1, lat8);
        end
        n_checks++;
        if ({sum_1, cout_1, ovf_1, zero_1} !== {8'h00, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL w8_d1_result: got %h c=%b v=%b z=%b expected 00 c=1 v=1 z=1", sum_1, cout_1, ovf_1, zero_1);
        end
        n_checks++;
        if ({sum_8, cout_8, ovf_8, zero_8} !== {8'h00, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL w8_d8_result: got %h c=%b v=%b z=%b expected 00 c=1 v=1 z=1", sum_8, cout_8, ovf_8, zero_8);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_mid();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised multi-cycle adder/subtractor built from a chain of DIGIT full-adder cells.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, keeping the carry in a register between cycles.
- Produces sum, carry-out, signed overflow and zero flags, with a start/done handshake.
- Sits in the ALU datapath as the area-reduced alternative to a full-width ripple adder.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle (full-adder cells in the chain); 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; sampled only when ready=1.
- sub  input  1  0 = a+b, 1 = a-b; latched with operands.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- ready  output  1  1 when idle and able to accept start.
- busy  output  1  1 while an operation is in progress (= ~ready).
- done  output  1  one-cycle pulse marking valid new results.
- sum  output  WIDTH  result, registered, held until the next completion.
- cout  output  1  carry out of bit WIDTH-1; for sub, 1 = no borrow (a >= b unsigned).
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  output  1  1 when sum == 0.

Behaviour:
- N = WIDTH/DIGIT digit cycles per operation.
- Reset, asynchronous, from any state including mid-operation: state = IDLE, digit counter = 0, internal registers = 0, sum = 0, cout = 0, overflow = 0, zero = 0, done = 0, ready = 1, busy = 0. Any partial result is discarded.
- Two states: IDLE and RUN.
- IDLE:
  - ready = 1.
  - On a clk edge with start = 1: latch a into opA, latch (sub ? ~b : b) into opB, set carry register = sub, clear counter, go to RUN.
- RUN (ready = 0, busy = 1), on each edge:
  - Add the DIGIT LSBs of opA and opB plus the carry register through the full-adder chain.
  - Store carry-out of the chain in the carry register.
  - Shift opA and opB right by DIGIT.
  - Shift the digit result into the accumulator from the MSB end.
  - Increment the counter.
- On the Nth RUN edge:
  - Load sum from the final accumulator value.
  - cout = final chain carry.
  - overflow = carry into bit WIDTH-1 XOR cout, where the carry into bit WIDTH-1 is taken inside the last digit's chain.
  - zero = (final sum == 0).
  - done = 1 for exactly the following cycle; state -> IDLE.
- Latency: start sampled at edge E0; results and done are valid after edge EN, i.e. N cycles later.
- Throughput: one operation per N+1 cycles.
- start while busy: ignored; no queuing, no effect on the current operation.
- start in the done cycle: accepted, since state is IDLE. This is back-to-back operation; done still pulses exactly once for the prior result.
- a, b and sub may change freely after acceptance; only latched values are used.
- Outputs sum/cout/overflow/zero change only on completion or reset. They are never partially updated.
- Arithmetic is modulo 2^WIDTH. Subtraction is a + ~b + 1.

Test Plan:
- WIDTH=32, DIGIT=4, add 0xFFFFFFFF + 0x00000001 -> sum=0x00000000, cout=1, overflow=0, zero=1; done pulses 8 cycles after the start edge, for 1 cycle.
- Add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, cout=0, overflow=1, zero=0.
- Subtract:
  - 5-7 -> sum=0xFFFFFFFE, cout=0, overflow=0.
  - 7-5 -> sum=0x00000002, cout=1.
  - 0x80000000-1 -> sum=0x7FFFFFFF, cout=1, overflow=1.
- Start 0x10+0x20, pulse start again with 0x1+0x1 at cycle 3 -> second request ignored, result 0x30. Then assert start with 3+4 in the done cycle -> accepted, sum=0x7 exactly 8 cycles later.
- Start 0x12345678+0x11111111, assert rst at cycle 3 -> all outputs 0 and ready=1 immediately (asynchronous). After release, no done pulse until a new start.
- WIDTH=8, DIGIT=1, add 0x80+0x80 -> sum=0x00, cout=1, overflow=1, zero=1, done 8 cycles after start. Repeat with DIGIT=8 -> same result, done after 1 cycle.
